// File: rtl/addsub_pipe.sv
// addsub_pipe -- chunked, carry-pipelined adder/subtractor with valid/ready flow.
//
// The WIDTH-bit operation is split into STAGES chunks of C = WIDTH/STAGES bits.
// Stage k adds chunk k using the carry left behind by stage k-1. The operands,
// the partially built result and the running carry travel together as one beat.
// The last stage register is the output register.
//
// Optional feature macro: ADDSUB_PIPE_SAT_EN
//   When defined, an overflowing result is clamped to the most positive or most
//   negative value, depending on the sign of operand a.
//   When undefined, sum is the plain modulo 2^WIDTH result.
//
// Ports
//   clk        in   clock; all state changes on the rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   operand beat offered
//   in_ready   out  beat accepted this cycle (combinational on out_ready)
//   a, b       in   WIDTH-bit operands
//   cin        in   carry-in for addition; ignored when sub=1
//   sub        in   0: a+b+cin, 1: a-b
//   out_valid  out  result beat present
//   out_ready  in   downstream accepts the result
//   sum        out  WIDTH-bit result
//   cout       out  carry-out of the MSB chunk (for subtraction, 1 = no borrow)
//   ovf        out  signed two's-complement overflow
module addsub_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int C = WIDTH / STAGES;
    localparam logic [WIDTH-1:0] CHUNK_ONES = WIDTH'({C{1'b1}});

    // Per-stage state. b_reg holds the effective operand (already inverted
    // for subtraction), so later stages never need to know about sub.
    logic [STAGES-1:0] valid_reg;
    logic [WIDTH-1:0]  a_reg [STAGES];
    logic [WIDTH-1:0]  b_reg [STAGES];
    logic [WIDTH-1:0]  s_reg [STAGES];
    logic [STAGES-1:0] c_reg;

    // What each stage would load: source beat and the chunk-updated result.
    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] src_c;
    logic [WIDTH-1:0]  src_a  [STAGES];
    logic [WIDTH-1:0]  src_b  [STAGES];
    logic [WIDTH-1:0]  src_s  [STAGES];
    logic [WIDTH-1:0]  s_next [STAGES];
    logic [STAGES-1:0] c_next;
    logic [STAGES-1:0] load;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            // Bits below gi are forced to 1 so that the compare below only
            // looks at stages gi..STAGES-1.
            localparam logic [STAGES-1:0] LOWER = STAGES'((64'd1 << gi) - 64'd1);

            logic [C:0] chunk_add;

            if (gi == 0) begin : g_first
                assign src_v[gi] = in_valid;
                assign src_a[gi] = a;
                assign src_b[gi] = sub ? ~b : b;
                assign src_s[gi] = '0;
                assign src_c[gi] = sub | cin;
            end else begin : g_chain
                assign src_v[gi] = valid_reg[gi-1];
                assign src_a[gi] = a_reg[gi-1];
                assign src_b[gi] = b_reg[gi-1];
                assign src_s[gi] = s_reg[gi-1];
                assign src_c[gi] = c_reg[gi-1];
            end

            assign chunk_add = {1'b0, src_a[gi][gi*C +: C]}
                             + {1'b0, src_b[gi][gi*C +: C]}
                             + {{C{1'b0}}, src_c[gi]};

            assign s_next[gi] = (src_s[gi] & ~(CHUNK_ONES << (gi*C)))
                              | (WIDTH'(chunk_add[C-1:0]) << (gi*C));
            assign c_next[gi] = chunk_add[C];

            // A stage may load unless it and every stage after it are full
            // and the output is stalled. Written in closed form so the stall
            // chain is a flat function of valid_reg and out_ready.
            assign load[gi] = out_ready || ((valid_reg | LOWER) != {STAGES{1'b1}});
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg <= '0;
            c_reg     <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_reg[k] <= '0;
                b_reg[k] <= '0;
                s_reg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    valid_reg[k] <= src_v[k];
                    // Payload only moves with a real beat, so a held result
                    // is never disturbed by an upstream bubble.
                    if (src_v[k]) begin
                        a_reg[k] <= src_a[k];
                        b_reg[k] <= src_b[k];
                        s_reg[k] <= s_next[k];
                        c_reg[k] <= c_next[k];
                    end
                end
            end
        end
    end

    // Output decode from the last stage register; stable while stalled.
    logic             a_msb;
    logic             b_msb;
    logic [WIDTH-1:0] raw_sum;
    logic             ovf_w;

    assign a_msb   = a_reg[STAGES-1][WIDTH-1];
    assign b_msb   = b_reg[STAGES-1][WIDTH-1];
    assign raw_sum = s_reg[STAGES-1];
    assign ovf_w   = (a_msb == b_msb) && (raw_sum[WIDTH-1] != a_msb);

`ifdef ADDSUB_PIPE_SAT_EN
    assign sum = !ovf_w ? raw_sum :
                 (a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}});
`else
    assign sum = raw_sum;
`endif

    assign ovf       = ovf_w;
    assign cout      = c_reg[STAGES-1];
    assign out_valid = rst_n & valid_reg[STAGES-1];
    assign in_ready  = rst_n & load[0];

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe (WIDTH=16, STAGES=4).
module tb_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int vectors = 0;
    int miscompares = 0;

`ifdef ADDSUB_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    addsub_pipe #(.WIDTH(16), .STAGES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Whole-word reference: {ovf, cout, sum}
    function automatic logic [17:0] ref_calc(input logic [15:0] ra, input logic [15:0] rb,
                                             input logic rc, input logic rs);
        logic [15:0] beff;
        logic [16:0] t;
        logic        ov;
        logic [15:0] s;
        beff = rs ? ~rb : rb;
        t    = {1'b0, ra} + {1'b0, beff} + {16'd0, (rs ? 1'b1 : rc)};
        ov   = (ra[15] == beff[15]) && (t[15] != ra[15]);
        s    = t[15:0];
        if (SAT && ov) s = ra[15] ? 16'h8000 : 16'h7FFF;
        return {ov, t[16], s};
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        tick(); tick();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hs: out_valid=%b in_ready=%b, required 0 0", out_valid, in_ready);
        end
        vectors++;
        if (sum !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out: sum=%h cout=%b ovf=%b, required 0000 0 0", sum, cout, ovf);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
        end
        $display("reset: out_valid=%b in_ready=%b sum=%h", out_valid, in_ready, sum);
    endtask

    task automatic test_directed;
        logic [15:0] va [10];
        logic [15:0] vb [10];
        logic        vc [10];
        logic        vs [10];
        logic [15:0] esum [10];
        logic [15:0] esat [10];
        logic        ecout [10];
        logic        eovf [10];
        logic [15:0] exp_sum;
        int          lat;
        va    = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h1234, 16'h0010, 16'h8000, 16'h7FFF, 16'h0FFF};
        vb    = '{16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h4321, 16'h0010, 16'h8000, 16'hFFFF, 16'hF001};
        vc    = '{1'b0,     1'b0,     1'b0,     1'b0,     1'b0,     1'b1,     1'b1,     1'b0,     1'b0,     1'b0};
        vs    = '{1'b0,     1'b0,     1'b0,     1'b1,     1'b1,     1'b0,     1'b1,     1'b0,     1'b1,     1'b0};
        esum  = '{16'h0100, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF, 16'h5556, 16'h0000, 16'h0000, 16'h8000, 16'h0000};
        esat  = '{16'h0100, 16'h0000, 16'h7FFF, 16'hFFFE, 16'h8000, 16'h5556, 16'h0000, 16'h8000, 16'h7FFF, 16'h0000};
        ecout = '{1'b0,     1'b1,     1'b0,     1'b0,     1'b1,     1'b0,     1'b1,     1'b1,     1'b0,     1'b1};
        eovf  = '{1'b0,     1'b0,     1'b1,     1'b0,     1'b1,     1'b0,     1'b0,     1'b1,     1'b1,     1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_sum = SAT ? esat[i] : esum[i];
            a = va[i]; b = vb[i]; cin = vc[i]; sub = vs[i]; in_valid = 1'b1;
            #1;
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL dir%0d_ready: in_ready=%b, required 1", i, in_ready);
            end
            tick();
            in_valid = 1'b0;
            lat = 1;
            while (out_valid !== 1'b1 && lat < 20) begin
                tick();
                lat++;
            end
            vectors++;
            if (lat != 4) begin
                miscompares++;
                $display("FAIL dir%0d_latency: %0d cycles, required 4", i, lat);
            end
            vectors++;
            if (sum !== exp_sum || cout !== ecout[i] || ovf !== eovf[i]) begin
                miscompares++;
                $display("FAIL dir%0d_result: sum=%h cout=%b ovf=%b, required %h %b %b",
                         i, sum, cout, ovf, exp_sum, ecout[i], eovf[i]);
            end
            $display("dir%0d: a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b lat=%0d",
                     i, va[i], vb[i], vc[i], vs[i], sum, cout, ovf, lat);
            tick();
        end
    endtask

    task automatic test_back_to_back;
        logic [17:0] q[$];
        logic [17:0] exp;
        logic [15:0] ba [8];
        int          sent;
        for (int i = 0; i < 8; i++) ba[i] = 16'h0F0F + 16'(i) * 16'h1111;
        b = 16'h00F1; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b0;
        sent = 0;
        for (int i = 0; i < 4; i++) begin
            a = ba[sent]; in_valid = 1'b1;
            #1;
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_fill%0d: in_ready=%b, required 1", i, in_ready);
            end
            q.push_back(ref_calc(a, b, cin, sub));
            sent++;
            tick();
        end
        a = ba[sent];
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_full_stall: in_ready=%b, required 0", in_ready);
        end
        for (int k = 0; k < 8; k++) begin
            out_ready = 1'b1;
            in_valid  = (sent < 8);
            if (sent < 8) a = ba[sent];
            #1;
            exp = (q.size() > 0) ? q.pop_front() : 18'h0;
            vectors++;
            if (out_valid !== 1'b1 || {ovf, cout, sum} !== exp) begin
                miscompares++;
                $display("FAIL b2b_out%0d: valid=%b {ovf,cout,sum}=%h, required 1 %h",
                         k, out_valid, {ovf, cout, sum}, exp);
            end
            if (in_valid) begin
                vectors++;
                if (in_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_pass%0d: in_ready=%b, required 1", k, in_ready);
                end
                q.push_back(ref_calc(a, b, cin, sub));
                sent++;
            end
            $display("b2b%0d: out_valid=%b sum=%h in_ready=%b", k, out_valid, sum, in_ready);
            tick();
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_stream;
        logic [15:0] sa [20];
        logic [15:0] sb [20];
        logic        sc [20];
        logic        ss [20];
        logic [17:0] q[$];
        logic [17:0] exp;
        logic [17:0] held;
        logic        stall_prev;
        logic        acc;
        logic        fire;
        int          sent, recv, occ, cyc;
        for (int i = 0; i < 20; i++) begin
            sa[i] = 16'($urandom); sb[i] = 16'($urandom);
            sc[i] = 1'($urandom); ss[i] = 1'($urandom);
        end
        sent = 0; recv = 0; occ = 0; cyc = 0;
        stall_prev = 1'b0; held = '0;
        while (recv < 20 && cyc < 1000) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (sent < 20);
            if (sent < 20) begin
                a = sa[sent]; b = sb[sent]; cin = sc[sent]; sub = ss[sent];
            end
            #1;
            vectors++;
            if (in_ready !== ((occ < 4) || out_ready)) begin
                miscompares++;
                $display("FAIL stream_ready c%0d: in_ready=%b, required %b (occ=%0d)",
                         cyc, in_ready, (occ < 4) || out_ready, occ);
            end
            if (stall_prev) begin
                vectors++;
                if (out_valid !== 1'b1 || {ovf, cout, sum} !== held) begin
                    miscompares++;
                    $display("FAIL stream_hold c%0d: valid=%b {ovf,cout,sum}=%h, required 1 %h",
                             cyc, out_valid, {ovf, cout, sum}, held);
                end
            end
            fire = out_valid && out_ready;
            if (fire) begin
                exp = (q.size() > 0) ? q.pop_front() : 18'h3FFFF;
                vectors++;
                if ({ovf, cout, sum} !== exp) begin
                    miscompares++;
                    $display("FAIL stream_beat%0d: {ovf,cout,sum}=%h, required %h",
                             recv, {ovf, cout, sum}, exp);
                end
                $display("stream beat%0d: sum=%h cout=%b ovf=%b", recv, sum, cout, ovf);
                recv++;
            end
            stall_prev = out_valid && !out_ready;
            held = {ovf, cout, sum};
            acc = in_valid && in_ready;
            if (acc) begin
                q.push_back(ref_calc(a, b, cin, sub));
                sent++;
            end
            occ = occ + (acc ? 1 : 0) - (fire ? 1 : 0);
            tick();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        vectors++;
        if (recv != 20) begin
            miscompares++;
            $display("FAIL stream_count: received %0d beats, required 20", recv);
        end
    endtask

    task automatic test_reset_inflight;
        out_ready = 1'b1; b = 16'h0001; cin = 1'b0; sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 16'h0100 * 16'(i + 1); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_active: out_valid=%b in_ready=%b, required 0 0", out_valid, in_ready);
        end
        tick();
        rst_n = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || sum !== 16'h0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_after: out_valid=%b sum=%h in_ready=%b, required 0 0000 1",
                     out_valid, sum, in_ready);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_stale%0d: out_valid=%b sum=%h, required 0", i, out_valid, sum);
            end
        end
        $display("reset_inflight: out_valid=%b in_ready=%b sum=%h", out_valid, in_ready, sum);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_stream();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/addsub_pipe.md
ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter STAGES, default 4, pipeline stages; WIDTH SHALL be an integer multiple of STAGES; chunk width C = WIDTH/STAGES.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block accepts beat this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in; ignored when sub=1.
REQ-010 sub  input  1  0: a+b+cin; 1: a-b (a + ~b + 1).
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 sum  output  WIDTH  result, modulo 2^WIDTH (or saturated, REQ-031).
REQ-014 cout  output  1  carry-out of MSB chunk (for sub: 1 = no borrow).
REQ-015 ovf  output  1  signed two's-complement overflow of the operation.

Function
REQ-016 Beat transfers on input when in_valid && in_ready; on output when out_valid && out_ready.
REQ-017 Stage k (0..STAGES-1) SHALL add chunk bits [k*C +: C] of a and effective b using carry from stage k-1 (stage 0 uses cin, or 1 when sub=1); not-yet-added upper chunks and lower result chunks SHALL travel with the beat.
REQ-018 Each stage SHALL hold a valid bit; stage k loads when it is empty or its content moves to stage k+1 (or out, for the last stage) in the same cycle.
REQ-019 in_ready SHALL equal !valid[0] || stage 0 advancing; it is combinational on out_ready through the stall chain.
REQ-020 Latency SHALL be exactly STAGES cycles from input transfer to out_valid with out_ready held high; throughput one beat per cycle.
REQ-021 While out_valid && !out_ready, sum, cout, ovf SHALL hold stable; upstream bubbles SHALL be squeezed out (a stage with valid=0 accepts even when downstream stalls).
REQ-022 Beats SHALL exit in arrival order; none lost or duplicated under any in_valid/out_ready pattern.
REQ-023 ovf SHALL be (sign A == sign Beff) && (sign result != sign A), Beff = b or ~b per sub.
REQ-024 Simultaneous output transfer and input transfer with pipeline full SHALL be allowed (no bubble inserted).
REQ-025 STAGES=1 SHALL give single-register adder, latency 1.

Reset
REQ-026 On clk edge with rst_n=0, all valid bits SHALL clear; sum, cout, ovf SHALL be 0.
REQ-027 While rst_n=0, in_ready and out_valid SHALL be 0; in-flight beats are discarded.
REQ-028 First cycle after rst_n rises, in_ready SHALL be 1.

Configuration
REQ-029 Macro ADDSUB_PIPE_SAT_EN SHALL select saturation logic.
REQ-030 Without it: sum is modulo 2^WIDTH; ovf reported only.
REQ-031 With it: when ovf=1, sum SHALL be 2^(WIDTH-1)-1 if sign A=0, else 2^(WIDTH-1); cout and ovf unchanged; latency unchanged.

Verification
REQ-032 WIDTH=16, STAGES=4, out_ready=1: a=0x00FF, b=0x0001, cin=0, sub=0 -> sum=0x0100, cout=0, ovf=0, out_valid exactly 4 cycles after accept.
REQ-033 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001 -> sum=0x8000 (SAT_EN: 0x7FFF), ovf=1.
REQ-034 sub=1: a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0; a=0x8000, b=0x0001 -> sum=0x7FFF (SAT_EN: 0x8000), ovf=1.
REQ-035 Stream 20 random beats back-to-back, out_ready toggled random 50% -> results match reference model in order, outputs stable during stall, in_ready=0 only when all 4 stages full and stalled.
REQ-036 rst_n=0 for one cycle with 3 beats in flight -> next cycle out_valid=0, sum=0, in_ready=1; no stale beat emerges later.
